// File: rtl/btn_event_arbiter.sv
// Debounces raw push-buttons and queues one event per press.
// Pending presses are granted round-robin into a small valid/ready event FIFO.
module btn_event_arbiter #(
  parameter int unsigned N_BTN   = 4,
  parameter int unsigned ID_BITS = 2,
  parameter int unsigned DELAY   = 65535,
  parameter int unsigned BITS    = 16,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_BTN-1:0]   btn_in,
  output logic               evt_valid,
  output logic [ID_BITS-1:0] evt_id,
  input  logic               evt_ready,
  output logic               evt_drop,
  output logic [ID_BITS:0]   fifo_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [BITS-1:0] DelayC = BITS'(DELAY);
  localparam logic [ID_BITS:0] DepthC = (ID_BITS + 1)'(DEPTH);

  // Synchronizer
  logic [N_BTN-1:0] s1_q, s2_q;

  // Debounce
  logic [BITS-1:0]  cnt_q [N_BTN];
  logic [BITS-1:0]  cnt_d [N_BTN];
  logic [N_BTN-1:0] armed_q, armed_d;
  logic [N_BTN-1:0] detect;

  // Arbiter
  logic [N_BTN-1:0]   pend_q, pend_d;
  logic [ID_BITS-1:0] last_q, last_d;
  logic [ID_BITS-1:0] win;
  logic               found;
  logic               grant;
  logic [N_BTN-1:0]   grant_vec;
  logic               drop_q, drop_d;

  // FIFO
  logic [ID_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ID_BITS:0]   count_q, count_d;
  logic               push, pop, push_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N_BTN); i++) begin
      cnt_d[i]   = cnt_q[i];
      armed_d[i] = armed_q[i];
      detect[i]  = s2_q[i] & armed_q[i] & (cnt_q[i] == DelayC);
      if (!s2_q[i]) begin
        cnt_d[i]   = '0;
        armed_d[i] = 1'b1;
      end else begin
        if (cnt_q[i] != DelayC) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
        if (detect[i]) begin
          armed_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_BTN); i++) begin
        cnt_q[i] <= '0;
      end
      armed_q <= '1;
    end else begin
      for (int i = 0; i < int'(N_BTN); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      armed_q <= armed_d;
    end
  end

  assign evt_valid = (count_q != '0);
  assign pop       = evt_valid & evt_ready;
  assign push_ok   = (count_q < DepthC) | pop;

  // Round-robin search starting just after the last winner.
  always_comb begin
    int idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= int'(N_BTN); k++) begin
      idx = (int'(last_q) + k) % int'(N_BTN);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        win   = ID_BITS'(idx);
      end
    end
  end

  assign grant     = found & push_ok;
  assign push      = grant;
  assign grant_vec = grant ? (N_BTN'(1) << win) : '0;

  // A detect on a bit granted this same cycle re-pends it without counting as a merge.
  always_comb begin
    pend_d = (pend_q & ~grant_vec) | detect;
    drop_d = drop_q | (|(detect & pend_q & ~grant_vec));
    last_d = grant ? win : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      last_q <= ID_BITS'(N_BTN - 1);
      drop_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      last_q <= last_d;
      drop_q <= drop_d;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < int'(DEPTH); j++) begin
        mem_q[j] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= win;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  assign evt_id     = mem_q[rd_ptr_q];
  assign evt_drop   = drop_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Self-checking bench for btn_event_arbiter: vector table plus hand-written corner
// sequences, with an event scoreboard checked whenever the consumer accepts an event.
module tb_btn_event_arbiter;

  localparam int unsigned NB = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NB-1:0]  btn_in = '0;
  logic           evt_valid;
  logic [2:0]     evt_id;
  logic           evt_ready = 1'b0;
  logic           evt_drop;
  logic [3:0]     fifo_count;

  btn_event_arbiter #(
    .N_BTN  (5),
    .ID_BITS(3),
    .DELAY  (4),
    .BITS   (4),
    .DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready),
    .evt_drop  (evt_drop),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         seen    = 0;
  logic [2:0] exp_q[$];

  typedef struct {
    logic [4:0]  mask;
    int          hold;
    int          n;
    logic [14:0] ids;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] ids5(input int a, input int b, input int c, input int d,
                                       input int e);
    return {3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  // Scoreboard: every accepted event must match the next expected id.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      seen++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected event: got id %0d expected none", evt_id);
      end else begin
        check("event id order", 32'(evt_id), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    btn_in    = '0;
    evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic push_exp(input int id);
    exp_q.push_back(3'(id));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] bpat;
    int         s0;

    vecs[0] = '{mask: 5'b00100, hold: 20, n: 1, ids: ids5(2, 0, 0, 0, 0)};
    vecs[1] = '{mask: 5'b00001, hold: 4,  n: 0, ids: ids5(0, 0, 0, 0, 0)};
    vecs[2] = '{mask: 5'b00001, hold: 5,  n: 1, ids: ids5(0, 0, 0, 0, 0)};
    vecs[3] = '{mask: 5'b01111, hold: 10, n: 4, ids: ids5(1, 2, 3, 0, 0)};
    vecs[4] = '{mask: 5'b10110, hold: 6,  n: 3, ids: ids5(1, 2, 4, 0, 0)};
    vecs[5] = '{mask: 5'b11111, hold: 6,  n: 5, ids: ids5(0, 1, 2, 3, 4)};
    vecs[6] = '{mask: 5'b00010, hold: 6,  n: 1, ids: ids5(1, 0, 0, 0, 0)};
    vecs[7] = '{mask: 5'b01111, hold: 6,  n: 4, ids: ids5(2, 3, 0, 1, 0)};

    do_reset();
    check("reset evt_valid", 32'(evt_valid), 0);
    check("reset evt_id", 32'(evt_id), 0);
    check("reset fifo_count", 32'(fifo_count), 0);
    check("reset evt_drop", 32'(evt_drop), 0);

    // Single press: valid exactly 7 cycles after first sampling edge.
    evt_ready = 1'b1;
    @(posedge clk);
    #1 btn_in = 5'b00100;
    push_exp(2);
    repeat (7) @(posedge clk);
    #1 check("latency E+6 valid", 32'(evt_valid), 0);
    @(posedge clk);
    #1 check("latency E+7 valid", 32'(evt_valid), 1);
    check("latency evt_id", 32'(evt_id), 2);
    repeat (12) @(posedge clk);
    #1 btn_in = '0;
    repeat (10) @(posedge clk);
    #1 check("single press drained", 32'(exp_q.size()), 0);

    // Bounce: longest run is 3 cycles, no event; then a clean hold.
    s0   = seen;
    bpat = 7'b0111011;
    for (int k = 6; k >= 0; k--) begin
      @(posedge clk);
      #1 btn_in = {4'b0, bpat[k]};
    end
    @(posedge clk);
    #1 btn_in = '0;
    repeat (10) @(posedge clk);
    #1 check("bounce no event", 32'(seen - s0), 0);
    btn_in = 5'b00001;
    push_exp(0);
    repeat (10) @(posedge clk);
    #1 btn_in = '0;
    repeat (10) @(posedge clk);
    #1 check("post-bounce drained", 32'(exp_q.size()), 0);

    // Vector table from a fresh round-robin pointer.
    do_reset();
    evt_ready = 1'b1;
    for (int v = 0; v < NV; v++) begin
      s0 = seen;
      @(posedge clk);
      #1 btn_in = vecs[v].mask;
      for (int k = 0; k < vecs[v].n; k++) begin
        exp_q.push_back(vecs[v].ids[3*k +: 3]);
      end
      repeat (vecs[v].hold) @(posedge clk);
      #1 btn_in = '0;
      repeat (20) @(posedge clk);
      #1 check($sformatf("vec%0d drained", v), 32'(exp_q.size()), 0);
      check($sformatf("vec%0d event count", v), 32'(seen - s0), 32'(vecs[v].n));
    end

    // Backpressure: five presses, FIFO holds four, fifth pushed on the pop cycle.
    do_reset();
    @(posedge clk);
    #1 btn_in = 5'b11111;
    for (int k = 0; k < 5; k++) push_exp(k);
    repeat (8) @(posedge clk);
    #1 btn_in = '0;
    repeat (10) @(posedge clk);
    #1 check("full fifo_count", 32'(fifo_count), 4);
    check("full evt_valid", 32'(evt_valid), 1);
    check("full head id", 32'(evt_id), 0);
    repeat (3) @(posedge clk);
    #1 check("head stable while stalled", 32'(evt_id), 0);
    evt_ready = 1'b1;
    @(posedge clk);
    #1 evt_ready = 1'b0;
    check("push+pop when full count", 32'(fifo_count), 4);
    check("head after pop", 32'(evt_id), 1);
    repeat (3) @(posedge clk);
    #1 check("count holds at 4", 32'(fifo_count), 4);
    evt_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("backpressure drained", 32'(exp_q.size()), 0);
    check("backpressure empty", 32'(fifo_count), 0);

    // Merge: button 1 pending behind a full FIFO, pressed a second time.
    do_reset();
    @(posedge clk);
    #1 btn_in = 5'b11101;
    push_exp(0); push_exp(2); push_exp(3); push_exp(4);
    repeat (6) @(posedge clk);
    #1 btn_in = '0;
    repeat (10) @(posedge clk);
    #1 btn_in = 5'b00010;
    push_exp(1);
    repeat (6) @(posedge clk);
    #1 btn_in = '0;
    repeat (5) @(posedge clk);
    #1 check("drop before merge", 32'(evt_drop), 0);
    btn_in = 5'b00010;
    repeat (6) @(posedge clk);
    #1 btn_in = '0;
    repeat (5) @(posedge clk);
    #1 check("drop after merge", 32'(evt_drop), 1);
    check("merge fifo_count", 32'(fifo_count), 4);
    evt_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1 check("merge drained", 32'(exp_q.size()), 0);
    check("drop sticky", 32'(evt_drop), 1);

    // Async reset mid-count with two events queued; button held through reset.
    do_reset();
    @(posedge clk);
    #1 btn_in = 5'b00101;
    push_exp(0); push_exp(2);
    repeat (6) @(posedge clk);
    #1 btn_in = '0;
    repeat (10) @(posedge clk);
    #1 check("two queued", 32'(fifo_count), 2);
    btn_in = 5'b01000;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async reset valid", 32'(evt_valid), 0);
    check("async reset count", 32'(fifo_count), 0);
    check("async reset id", 32'(evt_id), 0);
    check("async reset drop", 32'(evt_drop), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push_exp(3);
    repeat (7) @(posedge clk);
    #1 check("held-through-reset E+6", 32'(evt_valid), 0);
    @(posedge clk);
    #1 check("held-through-reset E+7", 32'(evt_valid), 1);
    check("held-through-reset id", 32'(evt_id), 3);
    evt_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1 btn_in = '0;
    repeat (5) @(posedge clk);
    #1 check("held-through-reset drained", 32'(exp_q.size()), 0);
    check("final fifo_count", 32'(fifo_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
